// File: rtl/sm_arbiter_pkg.sv
// Shared definitions for the shared-memory arbiter: FSM encoding,
// default bus widths matching the gpu core, and the core-id width helper.
package sm_arbiter_pkg;

  localparam int SM_N_CORES_DEF = 16;
  localparam int SM_AW_DEF      = 12;
  localparam int SM_DW_DEF      = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RESP   = 3'd3,
    ST_DONE   = 3'd4
  } arb_state_e;

  // Width of a core index; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sm_arbiter_if.sv
// Core-array and SRAM-side signal bundle of the shared-memory arbiter.
// slave: the arbiter's view. master: the cores plus the SRAM macro.
interface sm_arbiter_if
  import sm_arbiter_pkg::*;
#(
  parameter int N_CORES = SM_N_CORES_DEF,
  parameter int AW      = SM_AW_DEF,
  parameter int DW      = SM_DW_DEF
);

  localparam int IDW = id_w(N_CORES);

  logic [N_CORES-1:0]    mem_req_ld;
  logic [N_CORES-1:0]    mem_req_st;
  logic [N_CORES*AW-1:0] addr_shared_memory;
  logic [N_CORES*DW-1:0] mem_dat_st;
  logic [N_CORES-1:0]    val_data;
  logic [DW-1:0]         mem_dat;
  logic                  sm_en;
  logic                  sm_we;
  logic [AW-1:0]         sm_addr;
  logic [DW-1:0]         sm_wdata;
  logic [DW-1:0]         sm_rdata;
  logic                  busy;
  logic [IDW-1:0]        grant_id;
  logic                  proto_err;

  modport slave (
    input  mem_req_ld, mem_req_st, addr_shared_memory, mem_dat_st, sm_rdata,
    output val_data, mem_dat, sm_en, sm_we, sm_addr, sm_wdata, busy, grant_id, proto_err
  );

  modport master (
    output mem_req_ld, mem_req_st, addr_shared_memory, mem_dat_st, sm_rdata,
    input  val_data, mem_dat, sm_en, sm_we, sm_addr, sm_wdata, busy, grant_id, proto_err
  );

endinterface

// File: rtl/sm_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requesting core
// found searching upward from ptr+1, wrapping modulo N_CORES.
module sm_arbiter_rr_pick
  import sm_arbiter_pkg::*;
#(
  parameter int N_CORES = SM_N_CORES_DEF,
  localparam int IDW    = id_w(N_CORES)
) (
  input  logic [N_CORES-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic               found,
  output logic [IDW-1:0]     idx
);

  int k;

  // Scan N_CORES positions starting just after ptr; the first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    k     = 0;
    for (int i = 1; i <= N_CORES; i++) begin
      k = (int'(ptr) + i) % N_CORES;
      if (!found && req[k]) begin
        found = 1'b1;
        idx   = IDW'(k);
      end
    end
  end

endmodule

// File: rtl/sm_arbiter.sv
// Round-robin arbiter serialising per-core load/store requests onto one
// single-port shared-memory SRAM. One transaction occupies RD_LAT+3 cycles:
// IDLE (grant + drive SRAM) -> ACCESS -> WAIT* -> RESP -> DONE.
module sm_arbiter
  import sm_arbiter_pkg::*;
#(
  parameter int N_CORES = SM_N_CORES_DEF,
  parameter int AW      = SM_AW_DEF,
  parameter int DW      = SM_DW_DEF,
  parameter int RD_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  sm_arbiter_if.slave bus
);

  localparam int IDW = id_w(N_CORES);
  localparam int CW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  arb_state_e         state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic               op_st_q, op_st_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sm_en_q, sm_en_d;
  logic               sm_we_q, sm_we_d;
  logic [AW-1:0]      sm_addr_q, sm_addr_d;
  logic [DW-1:0]      sm_wdata_q, sm_wdata_d;
  logic [N_CORES-1:0] val_data_q, val_data_d;
  logic [DW-1:0]      mem_dat_q, mem_dat_d;
  logic               busy_q, busy_d;
  logic               proto_err_q, proto_err_d;

  logic [N_CORES-1:0] pending;
  logic               pick_found;
  logic [IDW-1:0]     pick_idx;

  assign pending = bus.mem_req_ld | bus.mem_req_st;

  sm_arbiter_rr_pick #(
    .N_CORES(N_CORES)
  ) u_rr_pick (
    .req   (pending),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // State and registered-output flops; reset drops any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= IDW'(N_CORES - 1);
      grant_id_q  <= '0;
      op_st_q     <= 1'b0;
      cnt_q       <= '0;
      sm_en_q     <= 1'b0;
      sm_we_q     <= 1'b0;
      sm_addr_q   <= '0;
      sm_wdata_q  <= '0;
      val_data_q  <= '0;
      mem_dat_q   <= '0;
      busy_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      op_st_q     <= op_st_d;
      cnt_q       <= cnt_d;
      sm_en_q     <= sm_en_d;
      sm_we_q     <= sm_we_d;
      sm_addr_q   <= sm_addr_d;
      sm_wdata_q  <= sm_wdata_d;
      val_data_q  <= val_data_d;
      mem_dat_q   <= mem_dat_d;
      busy_q      <= busy_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Next-state: requests are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (pick_found) state_d = ST_ACCESS;
      ST_ACCESS: state_d = (RD_LAT > 1) ? ST_WAIT : ST_RESP;
      ST_WAIT:   if (cnt_q == CW'(1)) state_d = ST_RESP;
      ST_RESP:   state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output/datapath: latch the winner in IDLE, pulse val_data from RESP.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    op_st_d     = op_st_q;
    cnt_d       = cnt_q;
    sm_en_d     = sm_en_q;
    sm_we_d     = sm_we_q;
    sm_addr_d   = sm_addr_q;
    sm_wdata_d  = sm_wdata_q;
    val_data_d  = val_data_q;
    mem_dat_d   = mem_dat_q;
    busy_d      = (state_d != ST_IDLE);
    proto_err_d = proto_err_q | (|(bus.mem_req_ld & bus.mem_req_st));
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          rr_ptr_d   = pick_idx;
          grant_id_d = pick_idx;
          // A load wins when a core raises both requests at once.
          op_st_d    = bus.mem_req_st[pick_idx] & ~bus.mem_req_ld[pick_idx];
          sm_en_d    = 1'b1;
          sm_we_d    = op_st_d;
          sm_addr_d  = bus.addr_shared_memory[int'(pick_idx)*AW +: AW];
          sm_wdata_d = bus.mem_dat_st[int'(pick_idx)*DW +: DW];
        end
      end
      ST_ACCESS: begin
        sm_en_d = 1'b0;
        sm_we_d = 1'b0;
        cnt_d   = CW'(RD_LAT - 1);
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CW'(1);
      end
      ST_RESP: begin
        if (!op_st_q) mem_dat_d = bus.sm_rdata;
        val_data_d             = '0;
        val_data_d[grant_id_q] = 1'b1;
      end
      ST_DONE: begin
        val_data_d = '0;
      end
      default: begin
        val_data_d = '0;
      end
    endcase
  end

  assign bus.val_data  = val_data_q;
  assign bus.mem_dat   = mem_dat_q;
  assign bus.sm_en     = sm_en_q;
  assign bus.sm_we     = sm_we_q;
  assign bus.sm_addr   = sm_addr_q;
  assign bus.sm_wdata  = sm_wdata_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_sm_arbiter.sv
// Scoreboard bench for sm_arbiter: RD_LAT=1 instance for the functional
// traffic, RD_LAT=3 instance for reset-in-WAIT and restart latency,
// plus a standalone sweep of the round-robin picker.
`timescale 1ns/1ps
module tb_sm_arbiter;
  import sm_arbiter_pkg::*;

  localparam int N   = 16;
  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int IDW = id_w(N);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a = 1'b1;
  logic reset_b = 1'b1;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sm_arbiter_if #(.N_CORES(N), .AW(AW), .DW(DW)) bus_a ();
  sm_arbiter_if #(.N_CORES(N), .AW(AW), .DW(DW)) bus_b ();

  sm_arbiter #(.N_CORES(N), .AW(AW), .DW(DW), .RD_LAT(1)) u_dut_a (
    .clk(clk), .reset(reset_a), .bus(bus_a.slave)
  );
  sm_arbiter #(.N_CORES(N), .AW(AW), .DW(DW), .RD_LAT(3)) u_dut_b (
    .clk(clk), .reset(reset_b), .bus(bus_b.slave)
  );

  logic [N-1:0]   pk_req;
  logic [IDW-1:0] pk_ptr;
  logic           pk_found;
  logic [IDW-1:0] pk_idx;

  sm_arbiter_rr_pick #(.N_CORES(N)) u_pick (
    .req(pk_req), .ptr(pk_ptr), .found(pk_found), .idx(pk_idx)
  );

  // Default SRAM contents for never-written addresses.
  function automatic logic [7:0] pat(input logic [11:0] a);
    return a[7:0] ^ 8'hF9 ^ {a[11:8], 4'h0};
  endfunction

  // SRAM model A: one-cycle read latency, write on sm_we.
  bit [7:0]    mem_a [4096];
  bit [4095:0] wr_a;
  always @(posedge clk) begin
    if (bus_a.sm_en) begin
      if (bus_a.sm_we) begin
        mem_a[bus_a.sm_addr] <= bus_a.sm_wdata;
        wr_a[bus_a.sm_addr]  <= 1'b1;
      end else begin
        bus_a.sm_rdata <= wr_a[bus_a.sm_addr] ? mem_a[bus_a.sm_addr] : pat(bus_a.sm_addr);
      end
    end
  end

  // SRAM model B: read-only, three-cycle read latency.
  logic [7:0] pb0, pb1;
  always @(posedge clk) begin
    if (bus_b.sm_en) pb0 <= pat(bus_b.sm_addr);
    pb1            <= pb0;
    bus_b.sm_rdata <= pb1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    int         core;
    bit         st;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  mdat;
  } txn_t;

  txn_t       sb_q[$];
  logic [7:0] exp_mem [int];
  logic [7:0] last_mdat = 8'h00;
  bit         mon_on = 1'b0;
  int         en_cyc = 0;
  logic       prev_en = 1'b0;

  // Monitor: check SRAM access against the queue head, pop on val_data.
  always @(negedge clk) begin
    if (mon_on) begin
      if (bus_a.sm_en) begin
        chk("sm_en_width", prev_en, 0);
        if (sb_q.size() == 0) chk("sm_en_unexpected", bus_a.sm_en, 0);
        else begin
          chk("sm_addr", bus_a.sm_addr, sb_q[0].addr);
          chk("sm_we", bus_a.sm_we, sb_q[0].st);
          chk("grant_id", bus_a.grant_id, sb_q[0].core);
          if (sb_q[0].st) chk("sm_wdata", bus_a.sm_wdata, sb_q[0].wdata);
        end
        en_cyc <= cyc;
      end
      if (bus_a.val_data != '0) begin
        if (sb_q.size() == 0) chk("val_unexpected", bus_a.val_data, 0);
        else begin
          chk("val_data", bus_a.val_data, 32'd1 << sb_q[0].core);
          chk("mem_dat", bus_a.mem_dat, sb_q[0].mdat);
          chk("latency", cyc - en_cyc, 2);
          void'(sb_q.pop_front());
        end
      end
      prev_en <= bus_a.sm_en;
    end
  end

  task automatic expect_txn(input int k, input bit st, input logic [11:0] a, input logic [7:0] d);
    txn_t t;
    t.core = k; t.st = st; t.addr = a; t.wdata = d;
    if (st) begin
      exp_mem[int'(a)] = d;
      t.mdat = last_mdat;
    end else begin
      t.mdat = exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : pat(a);
      last_mdat = t.mdat;
    end
    sb_q.push_back(t);
  endtask

  task automatic drive_req(input int k, input bit ld, input bit st, input logic [11:0] a, input logic [7:0] d);
    bus_a.addr_shared_memory[k*AW +: AW] = a;
    bus_a.mem_dat_st[k*DW +: DW]         = d;
    bus_a.mem_req_ld[k]                  = ld;
    bus_a.mem_req_st[k]                  = st;
  endtask

  task automatic wait_val(input int k, input string tag);
    int n;
    n = 0;
    while (bus_a.val_data[k] !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (bus_a.val_data[k] !== 1'b1) chk({tag, "_timeout"}, bus_a.val_data[k], 1);
  endtask

  task automatic txn(input int k, input bit ld, input bit st, input logic [11:0] a, input logic [7:0] d, input string tag);
    @(negedge clk);
    expect_txn(k, st && !ld, a, d);
    drive_req(k, ld, st, a, d);
    wait_val(k, tag);
    drive_req(k, 1'b0, 1'b0, a, d);
  endtask

  initial begin
    int         stamp [4];
    int         n;
    logic [15:0] pats [5];
    bit         ef;
    int         ei;

    bus_a.mem_req_ld = '0; bus_a.mem_req_st = '0;
    bus_a.addr_shared_memory = '0; bus_a.mem_dat_st = '0;
    bus_b.mem_req_ld = '0; bus_b.mem_req_st = '0;
    bus_b.addr_shared_memory = '0; bus_b.mem_dat_st = '0;
    pk_req = '0; pk_ptr = '0;

    #1 reset_a = 1'b0; reset_b = 1'b0;
    #1;
    chk("rst_val_data", bus_a.val_data, 0);
    chk("rst_sm_en", bus_a.sm_en, 0);
    chk("rst_sm_we", bus_a.sm_we, 0);
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_grant_id", bus_a.grant_id, 0);
    chk("rst_proto_err", bus_a.proto_err, 0);
    chk("rst_mem_dat", bus_a.mem_dat, 0);
    chk("rst_sm_addr", bus_a.sm_addr, 0);
    chk("rst_sm_wdata", bus_a.sm_wdata, 0);

    // Picker sweep over every pointer value.
    pats[0] = 16'h0000; pats[1] = 16'h8421; pats[2] = 16'h0001;
    pats[3] = 16'hFFFF; pats[4] = 16'h1000;
    for (int p = 0; p < N; p++) begin
      for (int j = 0; j < 5; j++) begin
        pk_ptr = IDW'(p);
        pk_req = pats[j];
        #1;
        ef = 1'b0; ei = 0;
        for (int b = N - 1; b >= 0; b--) if (pats[j][b]) begin ef = 1'b1; ei = b; end
        for (int b = N - 1; b > p; b--) if (pats[j][b]) ei = b;
        chk("pick_found", pk_found, ef);
        if (ef) chk("pick_idx", pk_idx, ei);
      end
    end

    repeat (3) @(negedge clk);
    reset_a = 1'b1; reset_b = 1'b1;
    mon_on = 1'b1;

    // Single load, single store, read-back of the stored byte.
    txn(3, 1'b1, 1'b0, 12'h0A5, 8'h00, "ld3");
    @(negedge clk);
    chk("val_one_cycle", bus_a.val_data, 0);
    chk("busy_after", bus_a.busy, 0);
    chk("ld3_mem_dat", bus_a.mem_dat, 8'h5C);
    txn(7, 1'b0, 1'b1, 12'hFFF, 8'hA5, "st7");
    @(negedge clk);
    chk("st7_mem_dat_held", bus_a.mem_dat, 8'h5C);
    chk("st7_proto_err", bus_a.proto_err, 0);
    txn(4, 1'b1, 1'b0, 12'hFFF, 8'h00, "ld4");

    // Reset between tests so core 0 has first priority again.
    @(negedge clk);
    reset_a = 1'b0;
    #1 chk("mid_rst_busy", bus_a.busy, 0);
    last_mdat = 8'h00;
    @(negedge clk);
    reset_a = 1'b1;

    // Contention: 0, 5, 15 together; core 0 re-requests during core 15.
    @(negedge clk);
    expect_txn(0, 1'b0, 12'h100, 8'h00);
    expect_txn(5, 1'b0, 12'h205, 8'h00);
    expect_txn(15, 1'b0, 12'h3FF, 8'h00);
    drive_req(0, 1'b1, 1'b0, 12'h100, 8'h00);
    drive_req(5, 1'b1, 1'b0, 12'h205, 8'h00);
    drive_req(15, 1'b1, 1'b0, 12'h3FF, 8'h00);
    wait_val(0, "ct0");
    drive_req(0, 1'b0, 1'b0, 12'h100, 8'h00);
    wait_val(5, "ct5");
    drive_req(5, 1'b0, 1'b0, 12'h205, 8'h00);
    n = 0;
    while (!(bus_a.sm_en === 1'b1 && bus_a.grant_id === IDW'(15)) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (bus_a.sm_en !== 1'b1) chk("ct15_grant_timeout", bus_a.sm_en, 1);
    expect_txn(0, 1'b0, 12'h042, 8'h00);
    drive_req(0, 1'b1, 1'b0, 12'h042, 8'h00);
    wait_val(15, "ct15");
    drive_req(15, 1'b0, 1'b0, 12'h3FF, 8'h00);
    wait_val(0, "ct0b");
    drive_req(0, 1'b0, 1'b0, 12'h042, 8'h00);

    // Fairness: cores 1 and 2 hold their requests for four grants.
    @(negedge clk);
    expect_txn(1, 1'b0, 12'h011, 8'h00);
    expect_txn(2, 1'b0, 12'h022, 8'h00);
    expect_txn(1, 1'b0, 12'h011, 8'h00);
    expect_txn(2, 1'b0, 12'h022, 8'h00);
    drive_req(1, 1'b1, 1'b0, 12'h011, 8'h00);
    drive_req(2, 1'b1, 1'b0, 12'h022, 8'h00);
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (bus_a.val_data == '0 && n < 64) begin
        @(negedge clk);
        n++;
      end
      if (bus_a.val_data == '0) chk("fair_timeout", bus_a.val_data, 1);
      stamp[i] = cyc;
      if (i > 0) chk("fair_gap", stamp[i] - stamp[i-1], 4);
      if (i == 3) begin
        drive_req(1, 1'b0, 1'b0, 12'h011, 8'h00);
        drive_req(2, 1'b0, 1'b0, 12'h022, 8'h00);
      end
      @(negedge clk);
    end

    // Protocol error: load and store together -> load, sticky flag.
    chk("pre_proto_err", bus_a.proto_err, 0);
    txn(2, 1'b1, 1'b1, 12'h010, 8'h77, "pe2");
    @(negedge clk);
    chk("proto_err_set", bus_a.proto_err, 1);
    chk("pe2_mem_dat", bus_a.mem_dat, 8'hE9);
    txn(9, 1'b1, 1'b0, 12'h0AB, 8'h00, "ld9");
    @(negedge clk);
    chk("proto_err_sticky", bus_a.proto_err, 1);
    chk("sb_drained", sb_q.size(), 0);

    // RD_LAT=3 instance: reset while in WAIT, then restart.
    @(negedge clk);
    bus_b.addr_shared_memory[6*AW +: AW] = 12'h123;
    bus_b.mem_req_ld[6] = 1'b1;
    n = 0;
    while (bus_b.sm_en !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (bus_b.sm_en !== 1'b1) chk("b_en_timeout", bus_b.sm_en, 1);
    @(negedge clk);
    chk("b_busy_in_wait", bus_b.busy, 1);
    reset_b = 1'b0;
    #1;
    chk("b_rst_sm_en", bus_b.sm_en, 0);
    chk("b_rst_val", bus_b.val_data, 0);
    chk("b_rst_busy", bus_b.busy, 0);
    repeat (2) begin
      @(negedge clk);
      chk("b_rst_no_pulse", bus_b.val_data, 0);
    end
    reset_b = 1'b1;
    n = 0;
    while (bus_b.val_data == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b_restart_lat", n, 5);
    chk("b_val_data", bus_b.val_data, 32'd1 << 6);
    chk("b_mem_dat", bus_b.mem_dat, pat(12'h123));
    bus_b.mem_req_ld[6] = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sm_arbiter.md
Name: sm_arbiter

Overview:
- Round-robin arbiter that shares one single-port shared-memory SRAM between N_CORES gpu cores.
- Each core raises a load or store request with an address and store data, then holds it until it sees its val_data pulse.
- The arbiter serialises these requests onto the SRAM port and returns load data on a broadcast bus.
- It sits between the core array and the shared-memory macro; the SRAM itself is outside this block.

Parameters:
- N_CORES, 16, number of requesting cores (2..16).
- AW, 12, shared-memory address width.
- DW, 8, data width.
- RD_LAT, 1, SRAM read latency in cycles after the enable edge (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- mem_req_ld  in  N_CORES  per-core load request, level, held until that core's val_data.
- mem_req_st  in  N_CORES  per-core store request, level, held until that core's val_data.
- addr_shared_memory  in  N_CORES*AW  per-core address; core k occupies slice [k*AW +: AW].
- mem_dat_st  in  N_CORES*DW  per-core store data, same slicing as the address.
- val_data  out  N_CORES  one-hot, one-cycle completion pulse to the granted core.
- mem_dat  out  DW  load data, broadcast to all cores; valid while val_data is high, then held.
- sm_en  out  1  SRAM access enable.
- sm_we  out  1  SRAM write enable (1 = store).
- sm_addr  out  AW  SRAM address.
- sm_wdata  out  DW  SRAM write data.
- sm_rdata  in  DW  SRAM read data, valid RD_LAT cycles after the edge that samples sm_en.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  $clog2(N_CORES)  index of the core currently being served.
- proto_err  out  1  sticky flag: some core asserted load and store in the same cycle.

Behaviour:
- Reset (reset=0, asynchronous): all outputs are 0, FSM goes to IDLE, rr_ptr = N_CORES-1 (so core 0 has first priority), latency counter = 0.
- A reset mid-transaction drops the access with no val_data pulse. The core keeps its request asserted and is re-served after reset is released.
- All outputs are registered.
- FSM states: IDLE, ACCESS, WAIT, RESP, DONE.
- IDLE:
  - pending = mem_req_ld | mem_req_st.
  - If pending is nonzero, pick the first set bit searching from rr_ptr+1 upward, wrapping modulo N_CORES.
  - Latch the winner's id, op, address and data. Drive sm_en=1, sm_we=op_is_store, sm_addr and sm_wdata from the latch. Set rr_ptr = id. Go to ACCESS.
- ACCESS (sm_en is high for exactly this one cycle):
  - sm_en <= 0, sm_we <= 0, counter <= RD_LAT-1.
  - Go to WAIT if RD_LAT>1, otherwise to RESP.
- WAIT: decrement the counter; go to RESP when it reaches 0.
- RESP:
  - For a load, mem_dat <= sm_rdata; for a store, mem_dat is unchanged.
  - val_data[id] <= 1. Go to DONE.
- DONE: val_data <= 0. Go to IDLE.
  - The core samples val_data at this edge and drops its request on the same edge, so IDLE never sees a stale request.
- Timing per transaction:
  - Request seen at edge t → sm_en high in cycle t+1 → val_data high in cycle t+RD_LAT+2.
  - Total occupancy is RD_LAT+3 cycles.
  - With RD_LAT=1, back-to-back throughput is one transaction per 4 cycles.
- Simultaneous load and store from one core: the load is performed and proto_err is set (sticky until reset).
- Requests that arrive during a transaction wait, and are evaluated only in IDLE.
- A request withdrawn while granted does not abort the transaction; val_data still pulses.
- Fairness: a core that is continuously requesting is served at least once every N_CORES grants.
- Address and data are used as latched in IDLE; later changes are ignored.

Decomposition:
- Shared package:
  - FSM state encoding for IDLE/ACCESS/WAIT/RESP/DONE.
  - AW/DW defaults, matching the core's 12-bit address and 8-bit data.
  - ID width function.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req[N_CORES], ptr.
  - Outputs: found, idx.
  - Verified standalone for all ptr values.

Test Plan:
- Single load: core 3 loads addr 0x0A5, SRAM holds 0x5C → sm_en=1 for 1 cycle with sm_addr=0x0A5 and sm_we=0; val_data=0x0008 for 1 cycle; mem_dat=0x5C.
- Single store: core 7 stores addr 0xFFF, data 0xA5 → sm_we=1, sm_addr=0xFFF, sm_wdata=0xA5; val_data=0x0080; mem_dat unchanged; proto_err=0.
- Contention: cores 0, 5 and 15 all load at once after reset → served in order 0, 5, 15. Core 0 requests again during core 15's transaction → it is served next.
- Fairness: cores 1 and 2 requesting continuously → grants alternate 1, 2, 1, 2; each val_data is spaced 4 cycles apart with RD_LAT=1.
- Protocol error: core 2 raises ld and st together at addr 0x010 → the load is executed and proto_err goes to 1 and stays there.
- Reset and latency:
  - Assert reset in WAIT with RD_LAT=3 → sm_en, val_data and busy go to 0 immediately with no pulse.
  - After release with the request still held → the transaction restarts and val_data appears 5 cycles after the request is sampled.
